// File: rtl/pe_controller.sv
// Leaf processing-element controller: takes CONFIG/CALC flits from the router,
// sums a 16-entry register file, then returns one FIN flit under credit flow control.
// Optional build macro PE_CTRL_ADDR_FILTER_EN: CONFIG writes land only when
// in_data[31:24] matches PE_ID; otherwise every CONFIG write is a broadcast.

`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 36
`endif
`ifndef ROUTER_INFO_CONFIG
`define ROUTER_INFO_CONFIG 4'h1
`endif
`ifndef ROUTER_INFO_CALC
`define ROUTER_INFO_CALC 4'h2
`endif
`ifndef ROUTER_INFO_FIN_BROADCAST
`define ROUTER_INFO_FIN_BROADCAST 4'h3
`endif
`ifndef ROUTER_FIFO_DEPTH
`define ROUTER_FIFO_DEPTH 4
`endif
`ifndef CREDIT_CNT_WIDTH
`define CREDIT_CNT_WIDTH 3
`endif

module pe_controller #(
  parameter logic [7:0] PE_ID = 8'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_data_valid,
  input  logic [`ROUTER_WIDTH-1:0] in_data,
  output logic                     upstream_credit,
  output logic                     out_data_valid,
  output logic [`ROUTER_WIDTH-1:0] out_data,
  input  logic                     downstream_credit,
  output logic [15:0]              result,
  output logic                     result_valid
);

  localparam int unsigned CNT_W   = `CREDIT_CNT_WIDTH;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ENTRIES = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPUTE  = 2'd1,
    FIN_SEND = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   rf [ENTRIES];
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   acc_sum;
  logic [3:0]          idx;
  logic [CNT_W-1:0]    credit_cnt;
  logic [3:0]          info;
  logic                addr_ok;
  logic                cfg_we;
  logic                calc_start;
  logic                unused_bits;

  assign info        = in_data[35:32];
  assign acc_sum     = acc + rf[idx];
  assign unused_bits = ^in_data[31:20];

`ifdef PE_CTRL_ADDR_FILTER_EN
  assign addr_ok = (in_data[31:24] == PE_ID);
`else
  assign addr_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, flit decode and FIN emission (FIN valid is combinational on credit)
  always_comb begin
    state_nxt      = state;
    cfg_we         = 1'b0;
    calc_start     = 1'b0;
    out_data_valid = 1'b0;
    out_data       = '0;
    case (state)
      IDLE: begin
        if (in_data_valid) begin
          if (info == `ROUTER_INFO_CONFIG) begin
            cfg_we = addr_ok;
          end else if (info == `ROUTER_INFO_CALC) begin
            calc_start = 1'b1;
            state_nxt  = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        if (idx == 4'd15) state_nxt = FIN_SEND;
      end
      FIN_SEND: begin
        if (credit_cnt != '0) begin
          out_data_valid = 1'b1;
          out_data       = {`ROUTER_INFO_FIN_BROADCAST, 16'd0, 8'd0, PE_ID};
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Input credit return, one pulse per accepted flit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) upstream_credit <= 1'b0;
    else     upstream_credit <= in_data_valid;
  end

  // Register file writes from CONFIG flits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) rf[i] <= '0;
    end else if (cfg_we) begin
      rf[in_data[19:16]] <= in_data[15:0];
    end
  end

  // Accumulation over all entries and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      idx          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (calc_start) begin
      acc          <= '0;
      idx          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (state == COMPUTE) begin
      acc <= acc_sum;
      idx <= idx + 4'd1;
      if (idx == 4'd15) begin
        result       <= acc_sum;
        result_valid <= 1'b1;
      end
    end
  end

  // Downstream credit counter; simultaneous return and send cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CNT_W'(`ROUTER_FIFO_DEPTH);
    end else begin
      case ({downstream_credit, out_data_valid})
        2'b10:   credit_cnt <= credit_cnt + CNT_W'(1);
        2'b01:   credit_cnt <= credit_cnt - CNT_W'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

endmodule
